// File: rtl/snes_joy_pkg.sv
// Shared constants and types for the SNES controller serializer.
package snes_joy_pkg;

    // Button bit positions within a report; bit 0 is shifted out first.
    localparam int unsigned BtnB      = 0;
    localparam int unsigned BtnY      = 1;
    localparam int unsigned BtnSelect = 2;
    localparam int unsigned BtnStart  = 3;
    localparam int unsigned BtnUp     = 4;
    localparam int unsigned BtnDown   = 5;
    localparam int unsigned BtnLeft   = 6;
    localparam int unsigned BtnRight  = 7;
    localparam int unsigned BtnA      = 8;
    localparam int unsigned BtnX      = 9;
    localparam int unsigned BtnL      = 10;
    localparam int unsigned BtnR      = 11;

    localparam int unsigned DefaultPadBits = 16;

    // Per-port report state.
    typedef enum logic [1:0] {
        StIdle,
        StLatch,
        StShift
    } port_state_e;

endpackage

// File: rtl/snes_joy_port.sv
// One controller port: latch on strobe, shift one bit per joy_clk rising edge.
module snes_joy_port
    import snes_joy_pkg::*;
#(
    parameter int unsigned PadBits = DefaultPadBits
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [PadBits-1:0] btn_i,       // effective buttons, 1 = pressed
    input  logic               strb_i,
    input  logic               joy_clk_i,
    input  logic               connected_i,
    output logic               joy_di_o,
    output logic               read_done_o
);

    localparam int unsigned     CntW    = $clog2(PadBits + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(PadBits);
    localparam logic [CntW-1:0] CntLast = CntW'(PadBits - 1);

    port_state_e        state_q, state_d;
    logic [PadBits-1:0] sr_q, sr_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               clk_q;
    logic               arm_q;
    logic               done_q, done_d;
    logic               di_q, di_d;
    logic               shift_edge;

    // Next-state: strobe reloads and wins over a coincident clock edge.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        // arm_q masks the first cycle after reset release.
        shift_edge = arm_q & joy_clk_i & ~clk_q;

        if (strb_i) begin
            state_d = StLatch;
            sr_d    = ~btn_i;
            cnt_d   = '0;
        end else begin
            if (state_q == StLatch) begin
                state_d = StShift;
            end
            if (shift_edge) begin
                sr_d = {1'b0, sr_q[PadBits-1:1]};
                // Saturated once idle: no further counting or done pulses.
                if (state_q != StIdle) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
        end
        // Unplugged port reads as all buttons released.
        di_d = sr_d[0] | ~connected_i;
    end

    // State registers with asynchronous reset to the idle, all-released state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            sr_q    <= '1;
            cnt_q   <= CntFull;
            clk_q   <= 1'b0;
            arm_q   <= 1'b0;
            done_q  <= 1'b0;
            di_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            clk_q   <= joy_clk_i;
            arm_q   <= 1'b1;
            done_q  <= done_d;
            di_q    <= di_d;
        end
    end

    assign joy_di_o    = di_q;
    assign read_done_o = done_q;

endmodule

// File: rtl/snes_joy_serializer.sv
// Multi-port SNES controller serializer with shared strobe-driven turbo.
module snes_joy_serializer
    import snes_joy_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned PAD_BITS  = DefaultPadBits,
    parameter int unsigned TURBO_W   = 8
) (
    input  logic                          clk_sys,
    input  logic                          reset_n,
    input  logic [NUM_PORTS*PAD_BITS-1:0] buttons,
    input  logic [NUM_PORTS*PAD_BITS-1:0] turbo_en,
    input  logic [TURBO_W-1:0]            turbo_period,
    input  logic [NUM_PORTS-1:0]          connected,
    input  logic                          joy_strb,
    input  logic [NUM_PORTS-1:0]          joy_clk,
    output logic [NUM_PORTS-1:0]          joy_di,
    output logic [NUM_PORTS-1:0]          read_done
);

    logic               strb_q;
    logic               strb_fall;
    logic [TURBO_W-1:0] tcnt_q, tcnt_d;
    logic               turbo_phase_q, turbo_phase_d;

    // Turbo counter advances once per frame (strobe fall); period 0 parks it.
    always_comb begin
        tcnt_d        = tcnt_q;
        turbo_phase_d = turbo_phase_q;
        strb_fall     = strb_q & ~joy_strb;
        if (turbo_period == '0) begin
            tcnt_d        = '0;
            turbo_phase_d = 1'b0;
        end else if (strb_fall) begin
            // >= so a shortened period wraps immediately.
            if (tcnt_q >= turbo_period - 1'b1) begin
                tcnt_d        = '0;
                turbo_phase_d = ~turbo_phase_q;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end
    end

    // Turbo and strobe-history registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            strb_q        <= 1'b0;
            tcnt_q        <= '0;
            turbo_phase_q <= 1'b0;
        end else begin
            strb_q        <= joy_strb;
            tcnt_q        <= tcnt_d;
            turbo_phase_q <= turbo_phase_d;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [PAD_BITS-1:0] eff_buttons;

        // Turbo-enabled buttons read as released during the off phase.
        assign eff_buttons = buttons[p*PAD_BITS +: PAD_BITS]
                           & ~(turbo_en[p*PAD_BITS +: PAD_BITS] & {PAD_BITS{turbo_phase_q}});

        snes_joy_port #(
            .PadBits (PAD_BITS)
        ) u_port (
            .clk_i       (clk_sys),
            .rst_ni      (reset_n),
            .btn_i       (eff_buttons),
            .strb_i      (joy_strb),
            .joy_clk_i   (joy_clk[p]),
            .connected_i (connected[p]),
            .joy_di_o    (joy_di[p]),
            .read_done_o (read_done[p])
        );
    end

endmodule

// File: tb/tb_snes_joy_serializer.sv
// Scoreboard bench: stimulus pushes expected report bits and done tokens,
// a monitor pops and compares as the serial bus is read.
module tb_snes_joy_serializer;
    import snes_joy_pkg::*;

    localparam int NP = 2;
    localparam int PB = 16;
    localparam int TW = 8;

    logic             clk_sys = 1'b0;
    logic             reset_n = 1'b1;
    logic [NP*PB-1:0] buttons = '0;
    logic [NP*PB-1:0] turbo_en = '0;
    logic [TW-1:0]    turbo_period = '0;
    logic [NP-1:0]    connected = '1;
    logic             joy_strb = 1'b0;
    logic [NP-1:0]    joy_clk = '0;
    logic [NP-1:0]    joy_di;
    logic [NP-1:0]    read_done;

    snes_joy_serializer #(
        .NUM_PORTS (NP),
        .PAD_BITS  (PB),
        .TURBO_W   (TW)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .buttons      (buttons),
        .turbo_en     (turbo_en),
        .turbo_period (turbo_period),
        .connected    (connected),
        .joy_strb     (joy_strb),
        .joy_clk      (joy_clk),
        .joy_di       (joy_di),
        .read_done    (read_done)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int   port;
        int   idx;
        logic val;
    } exp_t;

    exp_t          data_q[$];
    int            done_q[$];
    int            checks = 0;
    int            fails = 0;
    logic [PB-1:0] exp_eff[NP];
    int            m_tcnt = 0;
    logic          m_phase = 1'b0;
    logic [NP-1:0] jc_prev = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a report bit is read just before each bench-issued clock rise.
    always @(negedge clk_sys) begin
        for (int p = 0; p < NP; p++) begin
            if (joy_clk[p] && !jc_prev[p] && !joy_strb) begin
                if (data_q.size() == 0) begin
                    check("data_queue_underflow", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = data_q.pop_front();
                    check("data_port", p, e.port);
                    check($sformatf("joy_di[%0d] bit %0d", p, e.idx), {31'd0, joy_di[p]},
                          {31'd0, e.val});
                end
            end
            if (read_done[p]) begin
                if (done_q.size() == 0) begin
                    check($sformatf("read_done[%0d] unexpected", p), 32'd1, 32'd0);
                end else begin
                    check("read_done_port", p, done_q.pop_front());
                end
            end
        end
        jc_prev = joy_clk;
    end

    task automatic tick();
        @(posedge clk_sys);
        #2;
    endtask

    // Reference: the values latched by a strobe under the current turbo phase.
    task automatic latch_model();
        if (turbo_period == '0) begin
            m_tcnt  = 0;
            m_phase = 1'b0;
        end
        for (int p = 0; p < NP; p++) begin
            exp_eff[p] = buttons[p*PB +: PB] & ~(turbo_en[p*PB +: PB] & {PB{m_phase}});
        end
    endtask

    // Reference: turbo advance at the strobe fall.
    task automatic fall_model();
        if (turbo_period != '0) begin
            if (m_tcnt >= int'(turbo_period) - 1) begin
                m_tcnt  = 0;
                m_phase = ~m_phase;
            end else begin
                m_tcnt++;
            end
        end
    endtask

    task automatic do_strobe(input int cycles);
        latch_model();
        joy_strb = 1'b1;
        repeat (cycles) tick();
        joy_strb = 1'b0;
        fall_model();
        tick();
    endtask

    task automatic clock_port(input int p, input int idx);
        exp_t e;
        e.port = p;
        e.idx  = idx;
        if (!connected[p]) e.val = 1'b1;
        else if (idx < PB) e.val = ~exp_eff[p][idx];
        else e.val = 1'b0;
        data_q.push_back(e);
        if (idx == PB - 1) done_q.push_back(p);
        joy_clk[p] = 1'b1;
        tick();
        joy_clk[p] = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
    endtask

    task automatic frame(input int n0, input int n1);
        do_strobe($urandom_range(1, 3));
        for (int i = 0; i < n0; i++) clock_port(0, i);
        for (int i = 0; i < n1; i++) clock_port(1, i);
    endtask

    function automatic int rand_len();
        case ($urandom_range(0, 3))
            0:       rand_len = PB;
            1:       rand_len = PB + 1 + int'($urandom_range(0, 2));
            2:       rand_len = 5;
            default: rand_len = int'($urandom_range(1, PB + 3));
        endcase
    endfunction

    initial begin
        #3 reset_n = 1'b0;
        #1;
        check("reset joy_di", {30'd0, joy_di}, 32'h3);
        check("reset read_done", {30'd0, read_done}, 32'h0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("post-reset joy_di", {30'd0, joy_di}, 32'h3);

        // B and UP pressed on port 0, 17 clocks.
        buttons = 32'h0000_0011;
        frame(PB + 1, PB);

        // Port 1 unplugged with everything pressed.
        connected = 2'b01;
        buttons   = 32'hFFFF_0000;
        frame(PB, PB);
        connected = 2'b11;

        // Turbo on B, period 2: pressed, pressed, released, released, ...
        turbo_period = '0;
        do_strobe(2);
        buttons      = 32'h0;
        buttons[BtnB] = 1'b1;
        turbo_en      = 32'h0;
        turbo_en[BtnB] = 1'b1;
        turbo_period = 8'd2;
        for (int f = 0; f < 8; f++) begin
            do_strobe(2);
            check($sformatf("turbo frame %0d", f), {31'd0, joy_di[0]}, (f >> 1) & 1);
        end
        frame(PB, PB);
        turbo_en     = '0;
        turbo_period = '0;

        // Clock edge coincident with strobe is ignored.
        buttons = 32'h0000_0001;
        latch_model();
        joy_strb   = 1'b1;
        joy_clk[0] = 1'b1;
        tick();
        joy_clk[0] = 1'b0;
        tick();
        tick();
        joy_strb = 1'b0;
        fall_model();
        tick();
        check("strobe wins joy_di[0]", {31'd0, joy_di[0]}, 32'd0);
        for (int i = 0; i < PB; i++) clock_port(0, i);

        // Restart after 5 clocks, then a full report.
        buttons = 32'h1234_8421;
        frame(5, 5);
        frame(PB, PB);

        // Reset mid-report.
        buttons = 32'h00F0_0F0F;
        frame(5, 0);
        #1 reset_n = 1'b0;
        #1;
        check("mid-report reset joy_di", {30'd0, joy_di}, 32'h3);
        check("mid-report reset read_done", {30'd0, read_done}, 32'h0);
        m_tcnt  = 0;
        m_phase = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        frame(PB, PB);

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            buttons  = $urandom();
            turbo_en = $urandom() & $urandom();
            if ($urandom_range(0, 3) == 0) turbo_period = TW'($urandom_range(0, 3));
            connected = ($urandom_range(0, 4) == 0) ? NP'($urandom_range(0, 3)) : '1;
            frame(rand_len(), rand_len());
        end

        repeat (4) tick();
        check("data queue drained", data_q.size(), 32'd0);
        check("done queue drained", done_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
